button_code_driver: RTL and testbench

Drives a single-bit button line with a programmed sequence of timed presses, emulating a person entering a multi-digit press-count code. It is the stimulus end of the button interface: its `button` output feeds the `button` input of the button lock, and its `lock_signal` input watches the lock's `signal` output. It is used in the final-project top level for self-test and auto-unlock, and as reusable stimulus in benches.

---
 rtl/button_code_driver_pkg.sv | 25 ++
 rtl/button_code_driver_cycle_timer.sv | 37 +++
 rtl/button_code_driver.sv | 170 +++++++++++++++++
 tb/tb_button_code_driver.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/button_code_driver_pkg.sv
// Shared definitions for the button stimulus driver: FSM state encodings,
// default segment timings and a small sizing helper.
package button_code_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_GAP   = 3'd2,
    ST_DGAP  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int DEF_PRESS_CYCLES     = 25;
  localparam int DEF_GAP_CYCLES       = 25;
  localparam int DEF_DIGIT_GAP_CYCLES = 50;
  localparam int DEF_DIGITS           = 4;
  localparam int DEF_DIGIT_W          = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_code_driver_cycle_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded
// segment so the owner can reload on the same edge without a dead cycle.
module cycle_timer
  import button_code_driver_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/button_code_driver.sv
// Emulates a person entering a multi-digit press-count code on a single
// button line, and records whether the watched lock signalled during the run.
module button_code_driver
  import button_code_driver_pkg::*;
#(
  parameter int PRESS_CYCLES     = DEF_PRESS_CYCLES,
  parameter int GAP_CYCLES       = DEF_GAP_CYCLES,
  parameter int DIGIT_GAP_CYCLES = DEF_DIGIT_GAP_CYCLES,
  parameter int DIGITS           = DEF_DIGITS,
  parameter int DIGIT_W          = DEF_DIGIT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIGITS*DIGIT_W-1:0]   code,
  input  logic                        lock_signal,
  output logic                        button,
  output logic                        busy,
  output logic                        done,
  output logic                        unlocked,
  output logic [2:0]                  dbg_state
);

  localparam int TW = $clog2(max3(PRESS_CYCLES, GAP_CYCLES, DIGIT_GAP_CYCLES) + 1);
  localparam int IW = $clog2(DIGITS + 1);
  localparam int CW = DIGITS * DIGIT_W;

  state_e            state_q, state_d;
  logic [CW-1:0]     code_q, code_d;
  logic [DIGIT_W-1:0] press_q, press_d;
  logic [IW-1:0]     digit_q, digit_d;
  logic              unlocked_q, unlocked_d;
  logic              button_q, busy_q, done_q;

  logic              t_load;
  logic [TW-1:0]     t_val;
  logic              t_expire;

  logic              enter;
  logic [IW-1:0]     enter_idx;
  logic [CW-1:0]     src_code;
  logic [DIGIT_W-1:0] enter_dig;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    press_d    = press_q;
    digit_d    = digit_q;
    unlocked_d = unlocked_q;
    t_load     = 1'b0;
    t_val      = '0;
    enter      = 1'b0;
    enter_idx  = digit_q;
    src_code   = code_q;
    enter_dig  = '0;

    if (lock_signal && (busy_q || done_q)) begin
      unlocked_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          code_d     = code;
          src_code   = code;
          unlocked_d = 1'b0;
          enter      = 1'b1;
          enter_idx  = '0;
        end
      end
      ST_PRESS: begin
        if (t_expire) begin
          state_d = ST_GAP;
          t_load  = 1'b1;
          t_val   = TW'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        if (t_expire) begin
          press_d = press_q - DIGIT_W'(1);
          if (press_q > DIGIT_W'(1)) begin
            state_d = ST_PRESS;
            t_load  = 1'b1;
            t_val   = TW'(PRESS_CYCLES);
          end else if (digit_q < IW'(DIGITS - 1)) begin
            state_d = ST_DGAP;
            t_load  = 1'b1;
            t_val   = TW'(DIGIT_GAP_CYCLES);
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_DGAP: begin
        if (t_expire) begin
          enter     = 1'b1;
          enter_idx = digit_q + IW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int k = 0; k < DIGITS; k++) begin
      if (enter_idx == IW'(k)) begin
        enter_dig = src_code[k*DIGIT_W +: DIGIT_W];
      end
    end

    // Starting a digit: a zero digit has no presses and falls straight
    // through to its inter-digit gap, or to FIN if it is the last one.
    if (enter) begin
      digit_d = enter_idx;
      press_d = enter_dig;
      if (enter_dig != '0) begin
        state_d = ST_PRESS;
        t_load  = 1'b1;
        t_val   = TW'(PRESS_CYCLES);
      end else if (enter_idx < IW'(DIGITS - 1)) begin
        state_d = ST_DGAP;
        t_load  = 1'b1;
        t_val   = TW'(DIGIT_GAP_CYCLES);
      end else begin
        state_d = ST_FIN;
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      press_q    <= '0;
      digit_q    <= '0;
      unlocked_q <= 1'b0;
      button_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      press_q    <= press_d;
      digit_q    <= digit_d;
      unlocked_q <= unlocked_d;
      button_q   <= (state_d == ST_PRESS);
      busy_q     <= (state_d == ST_PRESS) || (state_d == ST_GAP) || (state_d == ST_DGAP);
      done_q     <= (state_d == ST_FIN);
    end
  end

  assign button    = button_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign unlocked  = unlocked_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_button_code_driver.sv
// Bench for button_code_driver: directed cases from the test plan plus
// randomized codes, lock pulses and ignored re-starts against a waveform model.
module tb_button_code_driver;

  localparam int P  = 2;
  localparam int G  = 2;
  localparam int DG = 4;
  localparam int ND = 2;
  localparam int DW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ND*DW-1:0] code;
  logic           lock_signal;
  logic           button, busy, done, unlocked;
  logic [2:0]     dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {button, busy, done} per cycle after the accepted start.
  logic [2:0] exp_q[$];

  button_code_driver #(
    .PRESS_CYCLES     (P),
    .GAP_CYCLES       (G),
    .DIGIT_GAP_CYCLES (DG),
    .DIGITS           (ND),
    .DIGIT_W          (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .code        (code),
    .lock_signal (lock_signal),
    .button      (button),
    .busy        (busy),
    .done        (done),
    .unlocked    (unlocked),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference waveform built directly from the press-count description.
  task automatic build_model(input logic [ND*DW-1:0] c);
    int d;
    exp_q.delete();
    for (int i = 0; i < ND; i++) begin
      d = int'(c[i*DW +: DW]);
      for (int r = 0; r < d; r++) begin
        repeat (P) exp_q.push_back(3'b110);
        repeat (G) exp_q.push_back(3'b010);
      end
      if (i < ND - 1) repeat (DG) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic run_seq(input logic [ND*DW-1:0] c, input int lock_pct,
                         input int lock_at, input bit noisy);
    logic unl_exp;
    build_model(c);
    @(posedge clk); #1;
    code = c; start = 1'b1; lock_signal = 1'b0;
    @(posedge clk);
    unl_exp = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) code = ND*DW'($urandom);
      lock_signal = ((i + 1) == lock_at) || (int'($urandom_range(0, 99)) < lock_pct);
      @(negedge clk);
      check("wave", {button, busy, done}, exp_q[i]);
      if (i == 0) check("unl_clr", unlocked, 1'b0);
      if (lock_signal && (exp_q[i][1] || exp_q[i][0])) unl_exp = 1'b1;
      @(posedge clk);
    end
    #1; start = 1'b0; lock_signal = 1'b0;
    @(negedge clk);
    check("idle_out", {button, busy, done}, 3'b000);
    check("unlocked", unlocked, unl_exp);
    repeat (3) @(negedge clk);
    check("unl_hold", unlocked, unl_exp);
  endtask

  task automatic run_abort();
    @(posedge clk); #1;
    code = {3'd1, 3'd2}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_pre", button, 1'b1);
    #2 rst = 1'b0;
    #1 check("abort_async", {button, busy, done, unlocked}, 4'b0000);
    @(posedge clk); #1;
    check("abort_held", {button, busy, done}, 3'b000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", {button, busy, done}, 3'b000);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; code = '0; lock_signal = 1'b0;
    #1 check("rst_out", {button, busy, done, unlocked}, 4'b0000);
    #9 rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("quiet", {button, busy, done}, 3'b000);
    end

    run_seq({3'd1, 3'd2}, 0, -1, 1'b0);
    run_seq({3'd0, 3'd0}, 0, -1, 1'b0);
    run_seq({3'd1, 3'd2}, 0, -1, 1'b1);
    run_seq({3'd1, 3'd2}, 0, 14, 1'b0);
    run_seq({3'd0, 3'd0}, 0, -1, 1'b0);
    run_seq({3'd7, 3'd0}, 0, -1, 1'b0);
    run_seq({3'd0, 3'd7}, 0, -1, 1'b0);
    run_abort();
    run_seq({3'd1, 3'd2}, 0, -1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_seq(ND*DW'($urandom), 4, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
